dmem_arbiter: RTL and testbench

- Shares the single synchronous data-memory port between two requesters: the CPU MEM stage (dce/daddr/we/dre/din bundle) and an external master (program loader / DMA).
- Sits between the MEM stage and the data RAM.
- Owns arbitration, external burst locking and read-response routing.
- Stalls the pipeline whenever the CPU access is not granted.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_rr_pick.sv | 43 ++++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings for the data-memory arbiter
//
// Purpose: owner and FSM state encodings, byte-select width and the grant
//          vector type used by dmem_arbiter and dmem_rr_pick.
// Ports:   none (package).
package dmem_arbiter_pkg;

  localparam int DMEM_BSEL = 4;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_EXT  = 2'b10
  } dmem_state_e;

  typedef struct packed {
    logic cpu;
    logic ext;
  } dmem_gnt_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - combinational grant selection for the two requesters
//
// Purpose: picks the winner of the memory port for this cycle.
// Ports:   cpu_req/ext_req  - request bits (already gated by reset)
//          last_winner      - winner of the most recent conflict
//          lock_req         - previous grant was external and ext_lock is high
//          burst_cnt        - external grants so far in the current locked burst
//          gnt              - one-hot (or zero) grant vector
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       cpu_req,
  input  logic       ext_req,
  input  logic       last_winner,
  input  logic       lock_req,
  input  logic [3:0] burst_cnt,
  output dmem_gnt_t  gnt
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  always_comb begin
    gnt = '0;
    if (cpu_req && !ext_req) begin
      gnt.cpu = 1'b1;
    end else if (ext_req && !cpu_req) begin
      gnt.ext = 1'b1;
    end else if (cpu_req && ext_req) begin
      // A locked burst keeps the port until the budget runs out; after that
      // the conflict falls back to strict alternation.
      if (lock_req && (burst_cnt < MAX_BURST_C)) begin
        gnt.ext = 1'b1;
      end else if (last_winner == OWNER_CPU) begin
        gnt.ext = 1'b1;
      end else begin
        gnt.cpu = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between CPU MEM stage and external master
//
// Purpose: shares one synchronous data RAM port, stalls the CPU when it loses,
//          honours bounded external burst locking and routes read responses.
// Ports:   cpu_clk_50M/cpu_rst_n         - clock, async active-low reset
//          cpu_dce/daddr/we/dre/din      - CPU MEM-stage request bundle
//          cpu_stall/rvalid/dout         - CPU stall and read response
//          ext_req/addr/we/din/lock      - external master request bundle
//          ext_gnt/rvalid/dout           - external grant and read response
//          mem_ce/addr/we/din, mem_dout  - RAM port (read data one cycle later)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst_n,
  input  logic                 cpu_dce,
  input  logic [ADDR_W-1:0]    cpu_daddr,
  input  logic [DMEM_BSEL-1:0] cpu_we,
  input  logic [DMEM_BSEL-1:0] cpu_dre,
  input  logic [DATA_W-1:0]    cpu_din,
  output logic                 cpu_stall,
  output logic                 cpu_rvalid,
  output logic [DATA_W-1:0]    cpu_dout,
  input  logic                 ext_req,
  input  logic [ADDR_W-1:0]    ext_addr,
  input  logic [DMEM_BSEL-1:0] ext_we,
  input  logic [DATA_W-1:0]    ext_din,
  input  logic                 ext_lock,
  output logic                 ext_gnt,
  output logic                 ext_rvalid,
  output logic [DATA_W-1:0]    ext_dout,
  output logic                 mem_ce,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DMEM_BSEL-1:0] mem_we,
  output logic [DATA_W-1:0]    mem_din,
  input  logic [DATA_W-1:0]    mem_dout
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  // Byte read enables travel to WB through the pipeline, not through here.
  logic unused_dre;
  assign unused_dre = ^cpu_dre;

  dmem_state_e state_q, state_d;
  logic        last_winner_q, last_winner_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        rsp_pending_q, rsp_pending_d;
  logic        rsp_owner_q, rsp_owner_d;

  // Gating the requests with reset forces every grant-derived output to 0
  // for as long as reset is held, combinational paths included.
  logic      cpu_req, ext_req_v, lock_req;
  dmem_gnt_t gnt;

  assign cpu_req   = cpu_dce & cpu_rst_n;
  assign ext_req_v = ext_req & cpu_rst_n;
  assign lock_req  = (state_q == ST_EXT) & ext_lock;

  dmem_rr_pick #(
    .MAX_BURST(MAX_BURST)
  ) u_pick (
    .cpu_req    (cpu_req),
    .ext_req    (ext_req_v),
    .last_winner(last_winner_q),
    .lock_req   (lock_req),
    .burst_cnt  (burst_cnt_q),
    .gnt        (gnt)
  );

  always_comb begin
    state_d       = ST_IDLE;
    last_winner_d = last_winner_q;
    burst_cnt_d   = '0;
    rsp_pending_d = 1'b0;
    rsp_owner_d   = rsp_owner_q;

    if (gnt.cpu) begin
      state_d = ST_CPU;
    end else if (gnt.ext) begin
      state_d = ST_EXT;
    end

    if (cpu_req && ext_req_v) begin
      last_winner_d = gnt.ext ? OWNER_EXT : OWNER_CPU;
    end

    // Only external grants taken while the CPU waits consume the burst
    // budget; with the CPU idle the count holds and bursts run unbounded.
    if (gnt.ext) begin
      burst_cnt_d = burst_cnt_q;
      if (cpu_req && (burst_cnt_q != MAX_BURST_C)) begin
        burst_cnt_d = burst_cnt_q + 4'd1;
      end
    end

    if (gnt.cpu && (cpu_we == '0)) begin
      rsp_pending_d = 1'b1;
      rsp_owner_d   = OWNER_CPU;
    end else if (gnt.ext && (ext_we == '0)) begin
      rsp_pending_d = 1'b1;
      rsp_owner_d   = OWNER_EXT;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q       <= ST_IDLE;
      last_winner_q <= OWNER_CPU;
      burst_cnt_q   <= '0;
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= OWNER_CPU;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
    end
  end

  assign cpu_stall = cpu_req & ~gnt.cpu;
  assign ext_gnt   = ext_req_v & gnt.ext;

  assign mem_ce   = gnt.cpu | gnt.ext;
  assign mem_addr = gnt.cpu ? cpu_daddr : (gnt.ext ? ext_addr : '0);
  assign mem_we   = gnt.cpu ? cpu_we    : (gnt.ext ? ext_we   : '0);
  assign mem_din  = gnt.cpu ? cpu_din   : (gnt.ext ? ext_din  : '0);

  assign cpu_rvalid = rsp_pending_q & (rsp_owner_q == OWNER_CPU);
  assign ext_rvalid = rsp_pending_q & (rsp_owner_q == OWNER_EXT);
  assign cpu_dout   = cpu_rvalid ? mem_dout : '0;
  assign ext_dout   = ext_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_dce = 1'b0;
  logic [31:0] cpu_daddr = '0;
  logic [3:0]  cpu_we = '0;
  logic [3:0]  cpu_dre = '0;
  logic [31:0] cpu_din = '0;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_dout;
  logic        ext_req = 1'b0;
  logic [31:0] ext_addr = '0;
  logic [3:0]  ext_we = '0;
  logic [31:0] ext_din = '0;
  logic        ext_lock = 1'b0;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_dout;
  logic        mem_ce;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int n_vec = 0;
  int n_err = 0;
  bit run = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(MAX_BURST), .ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .cpu_dce(cpu_dce), .cpu_daddr(cpu_daddr), .cpu_we(cpu_we), .cpu_dre(cpu_dre),
    .cpu_din(cpu_din), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_we(ext_we), .ext_din(ext_din),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_dout(ext_dout),
    .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'hA5A5_0000;
    if (i == 1) return 32'h0000_1111;
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // RAM seen by the DUT, driven only by the DUT's memory port.
  logic [31:0] ram [64];
  logic [31:0] ram_rd_q;
  assign mem_dout = ram_rd_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      ram_rd_q <= '0;
    end else if (mem_ce) begin
      if (mem_we == 4'h0) ram_rd_q <= ram[mem_addr[7:2]];
      else for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  // Behavioural model: who: 0 none, 1 cpu, 2 ext.
  logic [31:0] mram [64];
  int          m_prev = 0;
  int          m_last = 1;
  int          m_streak = 0;
  int          m_pend = 0;
  logic [31:0] m_pdata = '0;
  int          m_win;
  logic [31:0] m_addr, m_din;
  logic [3:0]  m_we;

  always_comb begin
    m_win = 0;
    if (rst_n && cpu_dce && !ext_req) m_win = 1;
    else if (rst_n && ext_req && !cpu_dce) m_win = 2;
    else if (rst_n && cpu_dce && ext_req) begin
      if (m_prev == 2 && ext_lock && m_streak < MAX_BURST) m_win = 2;
      else m_win = (m_last == 1) ? 2 : 1;
    end
    m_addr = (m_win == 1) ? cpu_daddr : (m_win == 2) ? ext_addr : 32'h0;
    m_we   = (m_win == 1) ? cpu_we    : (m_win == 2) ? ext_we   : 4'h0;
    m_din  = (m_win == 1) ? cpu_din   : (m_win == 2) ? ext_din  : 32'h0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mram[i] <= init_word(i);
      m_prev <= 0; m_last <= 1; m_streak <= 0; m_pend <= 0; m_pdata <= '0;
    end else begin
      m_prev <= m_win;
      if (cpu_dce && ext_req) m_last <= m_win;
      if (m_win != 2) m_streak <= 0;
      else if (cpu_dce) m_streak <= (m_streak < MAX_BURST) ? m_streak + 1 : MAX_BURST;
      m_pend <= (m_win != 0 && m_we == 4'h0) ? m_win : 0;
      if (m_win != 0 && m_we == 4'h0) m_pdata <= mram[m_addr[7:2]];
      if (m_win != 0) for (int b = 0; b < 4; b++)
        if (m_we[b]) mram[m_addr[7:2]][8*b +: 8] <= m_din[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("mem_ce",     32'(mem_ce),     32'(m_win != 0));
      chk("mem_addr",   mem_addr,        m_addr);
      chk("mem_we",     32'(mem_we),     32'(m_we));
      chk("mem_din",    mem_din,         m_din);
      chk("cpu_stall",  32'(cpu_stall),  32'(rst_n && cpu_dce && m_win != 1));
      chk("ext_gnt",    32'(ext_gnt),    32'(m_win == 2));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend == 1));
      chk("ext_rvalid", 32'(ext_rvalid), 32'(m_pend == 2));
      chk("cpu_dout",   cpu_dout,        (m_pend == 1) ? m_pdata : 32'h0);
      chk("ext_dout",   ext_dout,        (m_pend == 2) ? m_pdata : 32'h0);
    end
  end

  task automatic cyc(input logic cd, input logic [31:0] ca, input logic [3:0] cw,
                     input logic [31:0] cdi, input logic er, input logic [31:0] ea,
                     input logic [3:0] ew, input logic [31:0] edi, input logic el);
    @(posedge clk); #1;
    cpu_dce = cd; cpu_daddr = ca; cpu_we = cw; cpu_din = cdi; cpu_dre = (cw == 4'h0) ? 4'hF : 4'h0;
    ext_req = er; ext_addr = ea; ext_we = ew; ext_din = edi; ext_lock = el;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  logic [5:0] burst_pat;

  initial begin
    burst_pat = 6'b10_1111;
    // Requests held high through reset must be fully masked.
    cpu_dce = 1'b1; ext_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_ce", 32'(mem_ce), 32'h0);
    chk("rst_stall",  32'(cpu_stall), 32'h0);
    chk("rst_gnt",    32'(ext_gnt), 32'h0);
    cpu_dce = 1'b0; ext_req = 1'b0; rst_n = 1'b1;

    // CPU read hits immediately; data the next cycle.
    cyc(1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("rd_ce", 32'(mem_ce), 32'h1);
    chk("rd_stall", 32'(cpu_stall), 32'h0);
    chk("rd_addr", mem_addr, 32'h10);
    idle();
    chk("rd_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("rd_dout", cpu_dout, 32'hDEAD_BEEF);
    chk("rd_ext_rvalid", 32'(ext_rvalid), 32'h0);

    // Unlocked conflict alternates starting with EXT.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h08, 4'h0, 32'h0, 1'b1, 32'h0C, 4'h0, 32'h0, 1'b0);
      chk("rr_gnt", 32'(ext_gnt), 32'((k % 2) == 0));
      chk("rr_stall", 32'(cpu_stall), 32'((k % 2) == 0));
    end
    idle();

    // Locked burst: enter ST_EXT alone, then MAX_BURST grants, CPU, EXT.
    cyc(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h00, 4'h0, 32'h0, 1'b1);
    chk("lk_enter", 32'(ext_gnt), 32'h1);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 32'h04, 4'h0, 32'h0, 1'b1, 32'h00, 4'h0, 32'h0, 1'b1);
      chk("lk_gnt", 32'(ext_gnt), 32'(burst_pat[k]));
    end
    idle();

    // External write with CPU idle produces no response.
    cyc(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h20, 4'hF, 32'h1234_5678, 1'b0);
    chk("wr_we", 32'(mem_we), 32'hF);
    chk("wr_din", mem_din, 32'h1234_5678);
    chk("wr_gnt", 32'(ext_gnt), 32'h1);
    idle();
    chk("wr_no_ext_rv", 32'(ext_rvalid), 32'h0);
    chk("wr_no_cpu_rv", 32'(cpu_rvalid), 32'h0);

    // Response routing on consecutive cycles, then read back the write.
    cyc(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h00, 4'h0, 32'h0, 1'b0);
    cyc(1'b1, 32'h04, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("rt_ext_rv", 32'(ext_rvalid), 32'h1);
    chk("rt_ext_dout", ext_dout, 32'hA5A5_0000);
    chk("rt_cpu_dout0", cpu_dout, 32'h0);
    cyc(1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("rt_cpu_rv", 32'(cpu_rvalid), 32'h1);
    chk("rt_cpu_dout", cpu_dout, 32'h0000_1111);
    chk("rt_ext_dout0", ext_dout, 32'h0);
    idle();
    chk("rt_wr_back", cpu_dout, 32'h1234_5678);

    // Reset asserted mid-burst with a read pending.
    cyc(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h00, 4'h0, 32'h0, 1'b1);
    cyc(1'b1, 32'h04, 4'h0, 32'h0, 1'b1, 32'h00, 4'h0, 32'h0, 1'b1);
    cyc(1'b1, 32'h04, 4'h0, 32'h0, 1'b1, 32'h00, 4'h0, 32'h0, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("ar_ce", 32'(mem_ce), 32'h0);
    chk("ar_gnt", 32'(ext_gnt), 32'h0);
    chk("ar_stall", 32'(cpu_stall), 32'h0);
    chk("ar_ext_rv", 32'(ext_rvalid), 32'h0);
    chk("ar_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    cpu_dce = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
    rst_n = 1'b1;
    idle();
    chk("ar_no_cpu_rv", 32'(cpu_rvalid), 32'h0);
    chk("ar_no_ext_rv", 32'(ext_rvalid), 32'h0);
    cyc(1'b1, 32'h08, 4'h0, 32'h0, 1'b1, 32'h0C, 4'h0, 32'h0, 1'b1);
    chk("ar_rr_gnt", 32'(ext_gnt), 32'h1);
    chk("ar_rr_stall", 32'(cpu_stall), 32'h1);
    idle();
    idle();

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
